// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter sharing one muldiv unit between two requesters.
// Define MULDIV_ARB_TIMEOUT_EN to add the BUSY watchdog (abort with err after TIMEOUT cycles).
module muldiv_arbiter #(
  parameter int OP1_W   = 32,
  parameter int OP2_W   = 64,
  parameter int TIMEOUT = 200
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             op0,
  input  logic             op1,
  input  logic [OP1_W-1:0] a0,
  input  logic [OP1_W-1:0] a1,
  input  logic [OP2_W-1:0] b0,
  input  logic [OP2_W-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err,
  output logic [OP2_W-1:0] result,
  output logic [OP1_W-1:0] md_opera1,
  output logic [OP2_W-1:0] md_opera2,
  output logic             md_start,
  output logic             md_muordi,
  output logic             md_reset,
  input  logic             md_valid,
  input  logic [OP2_W-1:0] md_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GNT,
    S_CLR,
    S_START,
    S_BUSY,
    S_DONE,
    S_ABORT
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_owner;
  logic             r_last;
  logic [OP1_W-1:0] r_opera1;
  logic [OP2_W-1:0] r_opera2;
  logic             r_muordi;
  logic [OP2_W-1:0] r_result;
  logic             w_pick1;
  logic             w_expired;

  // Watchdog: counts BUSY cycles; cleared whenever the FSM is outside BUSY.
`ifdef MULDIV_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || (r_state != S_BUSY)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_expired = (r_cnt == CNT_LAST);
`else
  assign w_expired = 1'b0;

  // TIMEOUT has no effect unless the watchdog is compiled in.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_pick1      = 1'b0;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    done0        = 1'b0;
    done1        = 1'b0;
    err          = 1'b0;
    md_start     = 1'b0;
    md_reset     = reset;
    case (r_state)
      S_IDLE: begin
        // Only one requester: it wins. Both: the one not served last wins.
        w_pick1 = (req0 && req1) ? ~r_last : req1;
        if (req0 || req1) begin
          w_state_next = S_GNT;
        end
      end
      S_GNT: begin
        gnt0         = ~reset & ~r_owner;
        gnt1         = ~reset & r_owner;
        w_state_next = S_CLR;
      end
      S_CLR: begin
        md_reset     = 1'b1;
        w_state_next = S_START;
      end
      S_START: begin
        md_start     = ~reset;
        w_state_next = S_BUSY;
      end
      S_BUSY: begin
        if (md_valid) begin
          w_state_next = S_DONE;
        end else if (w_expired) begin
          w_state_next = S_ABORT;
        end
      end
      S_DONE: begin
        done0        = ~reset & ~r_owner;
        done1        = ~reset & r_owner;
        w_state_next = S_IDLE;
      end
      S_ABORT: begin
        done0        = ~reset & ~r_owner;
        done1        = ~reset & r_owner;
        md_reset     = 1'b1;
`ifdef MULDIV_ARB_TIMEOUT_EN
        err          = ~reset;
`endif
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_opera1 <= '0;
      r_opera2 <= '0;
      r_muordi <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_next;
      // Operands are latched once at the winning edge and held until the next grant.
      if ((r_state == S_IDLE) && (w_state_next == S_GNT)) begin
        r_owner  <= w_pick1;
        r_opera1 <= w_pick1 ? a1 : a0;
        r_opera2 <= w_pick1 ? b1 : b0;
        r_muordi <= w_pick1 ? op1 : op0;
      end
      if (r_state == S_BUSY) begin
        if (md_valid) begin
          r_result <= md_result;
        end else if (w_expired) begin
          r_result <= '0;
        end
      end
      if ((r_state == S_DONE) || (r_state == S_ABORT)) begin
        r_last <= r_owner;
      end
    end
  end

  assign result    = r_result;
  assign md_opera1 = r_opera1;
  assign md_opera2 = r_opera2;
  assign md_muordi = r_muordi;

endmodule

// File: doc/muldiv_arbiter.md
Name: muldiv_arbiter

Overview:
- Shares one muldiv signed multiplier/divider between two requester ports with round-robin arbitration.
- Sequences each operation: clear the unit, pulse start, wait for valid, then return the result to the granted requester.
- Sits between client logic and the muldiv instance.
- Owns all muldiv control inputs: opera1, opera2, reset, start and muordi.

Parameters:
- OP1_W, 32, width of opera1 (multiplier/divisor) operand
- OP2_W, 64, width of opera2 (multiplicand/dividend) operand and of the result
- TIMEOUT, 200, maximum cycles spent in BUSY; used only when MULDIV_ARB_TIMEOUT_EN is defined

Ports:
- clock  in  1  single system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  operation request; held high until the matching gnt pulse
- op0 / op1  in  1  operation select: 1 = multiply, 0 = divide (drives muordi)
- a0 / a1  in  OP1_W  opera1 operand
- b0 / b1  in  OP2_W  opera2 operand
- gnt0 / gnt1  out  1  one-cycle pulse; operands captured on this cycle
- done0 / done1  out  1  one-cycle pulse; result valid on this cycle
- err  out  1  one-cycle pulse with done on timeout abort; constant 0 when the feature is absent
- result  out  OP2_W  last completed result; held until the next done
- md_opera1  out  OP1_W  to muldiv opera1
- md_opera2  out  OP2_W  to muldiv opera2
- md_start  out  1  to muldiv start
- md_muordi  out  1  to muldiv muordi
- md_reset  out  1  to muldiv reset
- md_valid  in  1  from muldiv valid
- md_result  in  OP2_W  from muldiv result

Behaviour:
- Reset:
  - State goes to IDLE; all gnt, done, err and md_start outputs are 0.
  - result, md_opera1, md_opera2 and md_muordi are 0.
  - md_reset = 1 while reset is high (reset passes through to the muldiv). The RR pointer is set so requester 0 wins first.
  - Reset asserted in any state aborts the operation immediately: no done, no gnt.
- States: IDLE -> CLR -> START -> BUSY -> DONE -> IDLE.
- IDLE:
  - When any req is high at an edge, pick the winner: if only one requests, that one wins; if both request, the one not granted last wins (RR pointer).
  - Next cycle: gnt<n> = 1. Capture a/b/op into md_opera1, md_opera2 and md_muordi, and record the owner. Enter CLR.
- CLR: md_reset = 1 for exactly one cycle, flushing stale muldiv state and valid. Enter START.
- START: md_start = 1 for exactly one cycle. Enter BUSY.
- BUSY:
  - md_valid is sampled only in this state; a high md_valid at an edge moves to DONE and registers md_result into result.
  - md_valid is ignored in all other states.
- DONE: done<owner> = 1 for one cycle; result is stable. Toggle the RR pointer to the owner. Return to IDLE.
- Operand hold: md_opera1, md_opera2 and md_muordi stay constant from CLR through DONE.
- Back-to-back: a new request can be granted on the first IDLE edge after DONE.
  - Minimum overhead is 5 cycles per operation plus muldiv latency.
- Requests raised or dropped outside IDLE are ignored; a req dropped before grant is never granted.
- A requester re-requesting immediately while the other is pending loses to the other (starvation-free).
- Result width is OP2_W; the value is passed through unmodified, with no sign handling in the arbiter.

Optional Feature:
MULDIV_ARB_TIMEOUT_EN:
- Defined:
  - A cycle counter clears on BUSY entry.
  - If TIMEOUT cycles elapse without md_valid, go to ABORT.
  - In ABORT: md_reset = 1 for one cycle, done<owner> = 1, err = 1, result = 0, RR pointer updated, then IDLE.
  - md_valid arriving on the same edge as expiry takes priority (normal DONE).
- Not defined: no counter; BUSY waits indefinitely; err tied to 0.

Test Plan:
- Reset, then req0 with op0=1, a0=32'h64, b0=64'hA; muldiv returns 1000:
  - gnt0 on the cycle after req, then md_reset 1 cycle, then md_start 1 cycle.
  - done0 with result = 64'h3E8; md_muordi = 1 throughout.
- req0 and req1 raised on the same edge, both held:
  - gnt0 first, then gnt1 after done0.
  - done1 carries req1's result; never two gnts outstanding.
- req1 (op1=0, a1=-32'h6, b1=64'hD) completes, then req0 and req1 raised together:
  - req0 wins (RR); md_opera2 stays 64'hD for the whole req1 operation even if b1 changes after gnt1.
- Stray md_valid = 1 in IDLE and in CLR: no done or state change; done appears only after valid in BUSY.
- reset pulsed during BUSY: next cycle IDLE with all outputs 0, md_reset high during reset, no done; a fresh req then completes normally.
- With MULDIV_ARB_TIMEOUT_EN and TIMEOUT=200, md_valid held low: after 200 BUSY cycles, done0 = err = 1 with result = 0 and md_reset pulsed; the next req is granted normally.
